// File: rtl/fib_pkg.sv
// Shared constants and state encoding for the Fibonacci generator/checker pair.
// Both ends import this so term width and seed values cannot drift apart.
package fib_pkg;

    localparam int FIB_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } chk_state_t;

    localparam int FIB_SEED0 = 0;
    localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fib_checker_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
// Ports: clock, reset (async, active-high), inc, count[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fib_checker.sv
// Receive-side monitor for the Fibonacci term stream; judges each valid term.
// Ports: clock, reset, term_in, term_valid -> expected, match, mismatch,
//        error_flag, locked, term_count, wrap_count, chk_state.
module fib_checker
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_W,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] term_in,
    input  logic             term_valid,
    output logic [WIDTH-1:0] expected,
    output logic             match,
    output logic             mismatch,
    output logic             error_flag,
    output logic             locked,
    output logic [CNT_W-1:0] term_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [1:0]       chk_state
);

    localparam logic [WIDTH-1:0] S0 = WIDTH'(FIB_SEED0);
    localparam logic [WIDTH-1:0] S1 = WIDTH'(FIB_SEED1);

    chk_state_t       state, state_n;
    logic [WIDTH-1:0] prev1, prev2;
    logic [WIDTH-1:0] prev1_n, prev2_n;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic             hit;
    logic             match_n, mismatch_n, wrap_inc;

    // Carry bit marks the term that no longer fits: the stream wraps to 0.
    assign sum = {1'b0, prev1} + {1'b0, prev2};
    assign ovf = sum[WIDTH];
    assign hit = (term_in == expected);

    always_comb begin
        expected = S0;
        unique case (state)
            IDLE: expected = S0;
            SEED: expected = S1;
            RUN:  expected = ovf ? S0 : sum[WIDTH-1:0];
            ERR:  expected = S0;
        endcase
    end

    always_comb begin
        state_n    = state;
        prev1_n    = prev1;
        prev2_n    = prev2;
        match_n    = 1'b0;
        mismatch_n = 1'b0;
        wrap_inc   = 1'b0;
        if (term_valid) begin
            unique case (state)
                IDLE: begin
                    // Non-zero terms are skipped while hunting for a start.
                    if (hit) begin
                        match_n = 1'b1;
                        state_n = SEED;
                    end
                end
                SEED: begin
                    if (hit) begin
                        match_n = 1'b1;
                        prev2_n = S0;
                        prev1_n = S1;
                        state_n = RUN;
                    end else begin
                        mismatch_n = 1'b1;
                        state_n    = ERR;
                    end
                end
                RUN: begin
                    if (hit) begin
                        match_n = 1'b1;
                        if (ovf) begin
                            wrap_inc = 1'b1;
                            state_n  = SEED;
                        end else begin
                            prev2_n = prev1;
                            prev1_n = term_in;
                        end
                    end else begin
                        mismatch_n = 1'b1;
                        state_n    = ERR;
                    end
                end
                ERR: begin
                    // A zero resyncs; error_flag is left set.
                    if (hit) begin
                        match_n = 1'b1;
                        state_n = SEED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            prev1      <= '0;
            prev2      <= '0;
            match      <= 1'b0;
            mismatch   <= 1'b0;
            error_flag <= 1'b0;
        end else begin
            state      <= state_n;
            prev1      <= prev1_n;
            prev2      <= prev2_n;
            match      <= match_n;
            mismatch   <= mismatch_n;
            error_flag <= error_flag | mismatch_n;
        end
    end

    sat_counter #(.W(CNT_W)) u_term_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (match_n),
        .count (term_count)
    );

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (wrap_inc),
        .count (wrap_count)
    );

    assign locked    = (state == SEED) || (state == RUN);
    assign chk_state = state;

endmodule

// File: tb/tb_fib_checker.sv
// Self-checking bench for fib_checker: directed scenarios plus random stream
// against a sequence-position model of the Fibonacci checker.
`timescale 1ns/1ps
module tb_fib_checker;

    localparam int W = 6;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  term_in = '0;
    logic          term_valid = 1'b0;
    logic [W-1:0]  expected;
    logic          match, mismatch, error_flag, locked;
    logic [CW-1:0] term_count, wrap_count;
    logic [1:0]    chk_state;

    fib_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .term_in    (term_in),
        .term_valid (term_valid),
        .expected   (expected),
        .match      (match),
        .mismatch   (mismatch),
        .error_flag (error_flag),
        .locked     (locked),
        .term_count (term_count),
        .wrap_count (wrap_count),
        .chk_state  (chk_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model: position in the precomputed sequence, plus hunting/error modes.
    int seq[$];
    int slen;
    bit m_hunt, m_err, m_flag, m_match, m_mis;
    int m_idx, m_tc, m_wc;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_expected();
        if (m_hunt || m_err) return 0;
        return (m_idx < slen) ? seq[m_idx] : 0;
    endfunction

    function automatic int m_state();
        if (m_hunt) return 0;
        if (m_err) return 3;
        return (m_idx == 1) ? 1 : 2;
    endfunction

    function automatic int sat(int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic m_reset();
        m_hunt = 1; m_err = 0; m_flag = 0;
        m_match = 0; m_mis = 0;
        m_idx = 0; m_tc = 0; m_wc = 0;
    endtask

    task automatic m_accept(int t);
        int e;
        e = m_expected();
        m_match = 0;
        m_mis = 0;
        if (m_hunt || m_err) begin
            if (t == 0) begin
                m_match = 1; m_hunt = 0; m_err = 0; m_idx = 1;
            end
        end else if (t == e) begin
            m_match = 1;
            if (m_idx == slen) begin
                m_wc = sat(m_wc);
                m_idx = 1;
            end else begin
                m_idx++;
            end
        end else begin
            m_mis = 1; m_err = 1; m_flag = 1;
        end
        if (m_match) m_tc = sat(m_tc);
    endtask

    task automatic check_regs(string tag);
        chk({tag, ".match"}, match, m_match);
        chk({tag, ".mismatch"}, mismatch, m_mis);
        chk({tag, ".error_flag"}, error_flag, m_flag);
        chk({tag, ".term_count"}, term_count, m_tc);
        chk({tag, ".wrap_count"}, wrap_count, m_wc);
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic step(bit v, int t);
        term_valid = v;
        term_in = W'(t);
        @(negedge clock);
        chk("expected", expected, m_expected());
        chk("locked", locked, (m_state() == 1 || m_state() == 2));
        chk("chk_state", chk_state, m_state());
        if (v) m_accept(t);
        else begin
            m_match = 0; m_mis = 0;
        end
        @(posedge clock);
        #1;
        check_regs("step");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        m_reset();
        chk("rst.chk_state", chk_state, 0);
        check_regs("rst");
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic feed_seq(int n);
        for (int i = 0; i < n; i++) step(1, seq[i]);
    endtask

    initial begin
        int a, b, tmp;
        a = 0; b = 1;
        seq.push_back(0);
        while (b < (1 << W)) begin
            seq.push_back(b);
            tmp = a + b; a = b; b = tmp;
        end
        slen = seq.size();
        m_reset();

        #4 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("init.chk_state", chk_state, 0);
        chk("init.expected", expected, 0);
        check_regs("init");
        @(posedge clock);
        #1;

        // Full sequence, then wrap into 0,1,1.
        feed_seq(slen);
        chk("seq.term_count", term_count, 11);
        chk("seq.exp_after_55", expected, 0);
        chk("seq.locked", locked, 1);
        step(1, 0); step(1, 1); step(1, 1);
        chk("wrap.wrap_count", wrap_count, 1);
        chk("wrap.term_count", term_count, 14);

        // Bad term then resync.
        do_reset();
        step(1, 0); step(1, 1); step(1, 1); step(1, 2); step(1, 4);
        chk("bad.mismatch", mismatch, 1);
        chk("bad.error_flag", error_flag, 1);
        chk("bad.chk_state", chk_state, 3);
        step(1, 0); step(1, 1);
        chk("resync.chk_state", chk_state, 2);
        chk("resync.error_flag", error_flag, 1);

        // Pre-lock hunting.
        do_reset();
        step(1, 7); step(1, 9); step(1, 0); step(1, 1);
        chk("hunt.term_count", term_count, 2);

        // Valid every other cycle.
        do_reset();
        for (int i = 0; i < slen; i++) begin
            step(1, seq[i]);
            step(0, $urandom);
        end
        chk("gap.term_count", term_count, 11);

        // Async reset mid-RUN, between edges.
        do_reset();
        feed_seq(7);
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk("async.chk_state", chk_state, 0);
        chk("async.term_count", term_count, 0);
        chk("async.expected", expected, 0);
        check_regs("async");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Random stream with occasional corruption and gaps.
        for (int i = 0; i < 600; i++) begin
            bit v;
            int t;
            v = ($urandom % 4) != 0;
            t = (($urandom % 8) == 0) ? int'($urandom % 64) : m_expected();
            step(v, t);
        end

        // Long clean run to saturate both counters.
        for (int i = 0; i < 270 * 12; i++) step(1, m_expected());
        chk("sat.term_count", term_count, 255);
        chk("sat.wrap_count", wrap_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
